imm_gen_pipe: RTL

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
`timescale 1ns/1ps
// imm_gen_pipe: RV32 immediate decoder feeding a DEPTH-entry output FIFO.
// An instruction is decoded combinationally and pushed on accept; the consumer
// pops with a valid/ready handshake. Outputs read zero whenever the FIFO is empty.
// Optional macro IMM_GEN_ILLEGAL_CHK_EN: flag unrecognised opcodes as illegal
// (ImmType=7, Illegal=1). When it is undefined, Illegal is tied low.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     Instruction,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] Immediate,
    output logic [2:0]      ImmType,
    output logic            Illegal
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
    if (DEPTH < 2 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("imm_gen_pipe: DEPTH must be a power of two in 2..8");
    end

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_ILL  = 3'd7
    } imm_type_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        imm_type_e       typ;
`ifdef IMM_GEN_ILLEGAL_CHK_EN
        logic            ill;
`endif
    } entry_t;

    entry_t         dec;
    logic [31:0]    imm32;
    entry_t         mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           push;
    logic           pop;

    // Decode the instruction word into a 32-bit immediate and its format.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        imm32   = '0;
        dec.typ = IMM_NONE;
`ifdef IMM_GEN_ILLEGAL_CHK_EN
        dec.ill = 1'b0;
`endif
        case (Instruction[6:0])
            OP_LOAD, OP_IMM, OP_JALR: begin
                imm32   = {{20{Instruction[31]}}, Instruction[31:20]};
                dec.typ = IMM_I;
            end
            OP_STORE: begin
                imm32   = {{20{Instruction[31]}}, Instruction[31:25], Instruction[11:7]};
                dec.typ = IMM_S;
            end
            OP_BRANCH: begin
                imm32   = {{19{Instruction[31]}}, Instruction[31], Instruction[7],
                           Instruction[30:25], Instruction[11:8], 1'b0};
                dec.typ = IMM_B;
            end
            OP_LUI, OP_AUIPC: begin
                imm32   = {Instruction[31:12], 12'b0};
                dec.typ = IMM_U;
            end
            OP_JAL: begin
                imm32   = {{11{Instruction[31]}}, Instruction[31], Instruction[19:12],
                           Instruction[20], Instruction[30:21], 1'b0};
                dec.typ = IMM_J;
            end
            OP_REG: begin
                imm32   = '0;
                dec.typ = IMM_NONE;
            end
            default: begin
                imm32   = '0;
`ifdef IMM_GEN_ILLEGAL_CHK_EN
                dec.typ = IMM_ILL;
                dec.ill = 1'b1;
`else
                dec.typ = IMM_NONE;
`endif
            end
        endcase
        // The 32-bit immediate already carries Instruction[31] as its sign.
        dec.imm = XLEN'($signed(imm32));
    end

    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Write the decoded entry into the slot at the write pointer.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; out_valid gates every read, so stale contents are never visible.
        if (push) begin
            mem[wr_ptr] <= dec;
        end
    end

    // Pointer and occupancy control; flush outranks push and pop.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Present the head entry, or zeros while the buffer is empty.
    always_comb begin
        Immediate = '0;
        ImmType   = IMM_NONE;
        Illegal   = 1'b0;
        if (out_valid) begin
            Immediate = mem[rd_ptr].imm;
            ImmType   = mem[rd_ptr].typ;
`ifdef IMM_GEN_ILLEGAL_CHK_EN
            Illegal   = mem[rd_ptr].ill;
`endif
        end
    end

endmodule
